// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU datapath and a word-only data memory.
// Sub-word stores are done as read-modify-write; loads return big-endian lanes, extended.
module dmem_lsu #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [5:0]  NOP_OP    = 6'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [5:0]  mem_op,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writevalue,
  input  logic [31:0] mem_readvalue
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [33:0] MEM_BYTES = 34'(MEM_WORDS) * 34'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state_r, state_s;
  logic [5:0]  op_r, op_s;
  logic [1:0]  lane_r, lane_s;
  logic [15:0] wdata_r, wdata_s;
  logic        req_ready_r, req_ready_s;
  logic        resp_valid_r, resp_valid_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        resp_error_r, resp_error_s;
  logic [5:0]  mem_op_r, mem_op_s;
  logic [31:0] mem_address_r, mem_address_s;
  logic [31:0] mem_writevalue_r, mem_writevalue_s;

  function automatic logic is_bad(input logic [5:0] op, input logic [31:0] addr);
    logic bad_v;
    case (op)
      OP_LB, OP_LBU, OP_SB: bad_v = 1'b0;
      OP_LH, OP_LHU, OP_SH: bad_v = addr[0];
      OP_LW, OP_SW:         bad_v = |addr[1:0];
      default:              bad_v = 1'b1;
    endcase
    return bad_v | ({2'b00, addr} >= MEM_BYTES);
  endfunction

  function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b_v;
    logic [15:0] h_v;
    logic [31:0] r_v;
    case (lane)
      2'd0:    b_v = word[31:24];
      2'd1:    b_v = word[23:16];
      2'd2:    b_v = word[15:8];
      default: b_v = word[7:0];
    endcase
    h_v = lane[1] ? word[15:0] : word[31:16];
    case (op)
      OP_LB:   r_v = {{24{b_v[7]}}, b_v};
      OP_LBU:  r_v = {24'd0, b_v};
      OP_LH:   r_v = {{16{h_v[15]}}, h_v};
      OP_LHU:  r_v = {16'd0, h_v};
      OP_LW:   r_v = word;
      default: r_v = 32'd0;
    endcase
    return r_v;
  endfunction

  function automatic logic [31:0] merge_store(input logic [5:0] op, input logic [1:0] lane,
                                              input logic [15:0] data, input logic [31:0] word);
    logic [31:0] r_v;
    r_v = word;
    case (op)
      OP_SB: begin
        case (lane)
          2'd0:    r_v[31:24] = data[7:0];
          2'd1:    r_v[23:16] = data[7:0];
          2'd2:    r_v[15:8]  = data[7:0];
          default: r_v[7:0]   = data[7:0];
        endcase
      end
      OP_SH: begin
        if (lane[1]) r_v[15:0]  = data;
        else         r_v[31:16] = data;
      end
      default: r_v = word;
    endcase
    return r_v;
  endfunction

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s          = state_r;
    op_s             = op_r;
    lane_s           = lane_r;
    wdata_s          = wdata_r;
    resp_valid_s     = resp_valid_r;
    resp_rdata_s     = resp_rdata_r;
    resp_error_s     = resp_error_r;
    mem_op_s         = NOP_OP;
    mem_address_s    = mem_address_r;
    mem_writevalue_s = mem_writevalue_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          op_s          = req_op;
          lane_s        = req_address[1:0];
          wdata_s       = req_wdata[15:0];
          mem_address_s = {req_address[31:2], 2'b00};
          resp_rdata_s  = 32'd0;
          if (is_bad(req_op, req_address)) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_error_s = 1'b1;
          end else begin
            state_s      = ACCESS;
            resp_error_s = 1'b0;
            // SW needs no read, so its single write cycle is the ACCESS cycle itself
            if (req_op == OP_SW) begin
              mem_op_s         = OP_SW;
              mem_writevalue_s = req_wdata;
            end else begin
              mem_op_s = NOP_OP;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        case (op_r)
          OP_SW: begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
          end
          OP_SB, OP_SH: begin
            state_s          = WRITE;
            mem_op_s         = OP_SW;
            mem_writevalue_s = merge_store(op_r, lane_r, wdata_r, mem_readvalue);
          end
          OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = load_extract(op_r, lane_r, mem_readvalue);
          end
          default: begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_error_s = 1'b1;
          end
        endcase
      end
      WRITE: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_s      = IDLE;
          resp_valid_s = 1'b0;
          resp_rdata_s = 32'd0;
          resp_error_s = 1'b0;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
    req_ready_s = (state_s == IDLE);
  end

  // State and output registers; reset abandons any pending write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= IDLE;
      op_r             <= 6'd0;
      lane_r           <= 2'd0;
      wdata_r          <= 16'd0;
      req_ready_r      <= 1'b1;
      resp_valid_r     <= 1'b0;
      resp_rdata_r     <= 32'd0;
      resp_error_r     <= 1'b0;
      mem_op_r         <= NOP_OP;
      mem_address_r    <= 32'd0;
      mem_writevalue_r <= 32'd0;
    end else begin
      state_r          <= state_s;
      op_r             <= op_s;
      lane_r           <= lane_s;
      wdata_r          <= wdata_s;
      req_ready_r      <= req_ready_s;
      resp_valid_r     <= resp_valid_s;
      resp_rdata_r     <= resp_rdata_s;
      resp_error_r     <= resp_error_s;
      mem_op_r         <= mem_op_s;
      mem_address_r    <= mem_address_s;
      mem_writevalue_r <= mem_writevalue_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign resp_valid     = resp_valid_r;
  assign resp_rdata     = resp_rdata_r;
  assign resp_error     = resp_error_r;
  assign mem_op         = mem_op_r;
  assign mem_address    = mem_address_r;
  assign mem_writevalue = mem_writevalue_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: the driver queues hand-computed expectations,
// a negedge monitor measures latency and write cycles and compares each response.
module tb_dmem_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [5:0]  mem_op;
  logic [31:0] mem_address;
  logic [31:0] mem_writevalue;
  logic [31:0] mem_readvalue;
  logic        mem_init;
  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wval;
  } exp_t;
  exp_t sb[$];

  dmem_lsu #(.MEM_WORDS(1024), .NOP_OP(6'h00)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_op(mem_op), .mem_address(mem_address),
    .mem_writevalue(mem_writevalue), .mem_readvalue(mem_readvalue)
  );

  always #5 clock = ~clock;

  assign mem_readvalue = mem[mem_address[11:2]];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h80FF7F01;
      mem[5] <= 32'h11223344;
    end else if (mem_op == 6'h2B) begin
      mem[mem_address[11:2]] <= mem_writevalue;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: latency and write counting per accepted request, then scoreboard compare.
  int          mon_cnt = 0;
  int          mon_wr = 0;
  logic        mon_active = 1'b0;
  logic [31:0] mon_waddr = 32'd0;
  logic [31:0] mon_wval = 32'd0;
  exp_t        e;

  always @(negedge clock) begin
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (mon_active) begin
        mon_cnt++;
        if (mem_op == 6'h2B) begin
          mon_wr++;
          mon_waddr = mem_address;
          mon_wval  = mem_writevalue;
        end
        if (resp_valid) begin
          mon_active = 1'b0;
          if (sb.size() == 0) begin
            timeout_fail("unexpected_response");
          end else begin
            e = sb.pop_front();
            check({e.name, "_rdata"}, resp_rdata, e.rdata);
            check({e.name, "_error"}, {31'd0, resp_error}, {31'd0, e.err});
            check({e.name, "_latency"}, mon_cnt, e.lat);
            check({e.name, "_writes"}, mon_wr, e.writes);
            if (e.writes > 0) begin
              check({e.name, "_waddr"}, mon_waddr, e.waddr);
              check({e.name, "_wval"}, mon_wval, e.wval);
            end
          end
        end else if (mon_cnt > 10) begin
          mon_active = 1'b0;
          timeout_fail("response_latency");
        end
      end else if (mem_op == 6'h2B) begin
        timeout_fail("stray_write_cycle");
      end
      if (req_valid && req_ready) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_wr     = 0;
      end
    end
  end

  task automatic wait_accept(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail({name, "_accept"});
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (resp_valid && resp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail({name, "_done"});
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_op      = op;
    req_address = addr;
    req_wdata   = wdata;
    req_valid   = 1'b1;
  endtask

  task automatic do_req(input string name, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                        input int lat, input int writes, input logic [31:0] waddr,
                        input logic [31:0] wval);
    sb.push_back('{name, rdata, err, lat, writes, waddr, wval});
    drive(op, addr, wdata);
    wait_accept(name);
    wait_done(name);
  endtask

  initial begin
    reset       = 1'b1;
    mem_init    = 1'b1;
    req_valid   = 1'b0;
    req_op      = 6'h00;
    req_address = 32'd0;
    req_wdata   = 32'd0;
    resp_ready  = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_mem_op", {26'd0, mem_op}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_writevalue", mem_writevalue, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    mem_init = 1'b0;

    // Loads from word[4] = 0x80FF7F01
    do_req("lb_10",  6'h20, 32'h10, 32'd0, 32'hFFFFFF80, 1'b0, 2, 0, 32'd0, 32'd0);
    do_req("lbu_10", 6'h24, 32'h10, 32'd0, 32'h00000080, 1'b0, 2, 0, 32'd0, 32'd0);
    do_req("lh_12",  6'h21, 32'h12, 32'd0, 32'h00007F01, 1'b0, 2, 0, 32'd0, 32'd0);
    do_req("lhu_10", 6'h25, 32'h10, 32'd0, 32'h000080FF, 1'b0, 2, 0, 32'd0, 32'd0);
    do_req("lb_12",  6'h20, 32'h12, 32'd0, 32'h0000007F, 1'b0, 2, 0, 32'd0, 32'd0);
    do_req("lh_10",  6'h21, 32'h10, 32'd0, 32'hFFFF80FF, 1'b0, 2, 0, 32'd0, 32'd0);
    // Stores
    do_req("sb_13",  6'h28, 32'h13, 32'h000000AB, 32'd0, 1'b0, 3, 1, 32'h10, 32'h80FF7FAB);
    do_req("lw_10",  6'h23, 32'h10, 32'd0, 32'h80FF7FAB, 1'b0, 2, 0, 32'd0, 32'd0);
    do_req("sw_20",  6'h2B, 32'h20, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 32'h20, 32'hDEADBEEF);
    do_req("lw_20",  6'h23, 32'h20, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0, 32'd0, 32'd0);
    // Errors
    do_req("err_lw_22",   6'h23, 32'h22,   32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);
    do_req("err_sh_11",   6'h29, 32'h11,   32'h1234, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);
    do_req("err_lw_1000", 6'h23, 32'h1000, 32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);
    do_req("err_op_3f",   6'h3F, 32'h10,   32'd0, 32'd0, 1'b1, 1, 0, 32'd0, 32'd0);

    // SH with reset landing on the ACCESS edge: write must be abandoned
    drive(6'h29, 32'h14, 32'h0000BEEF);
    wait_accept("sh_rst");
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("sh_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("sh_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(negedge clock);
    check("sh_rst_mem_word", mem[5], 32'h11223344);
    @(posedge clock);
    #1;
    do_req("lw_14",  6'h23, 32'h14, 32'd0, 32'h11223344, 1'b0, 2, 0, 32'd0, 32'd0);
    do_req("sh_16",  6'h29, 32'h16, 32'h0000BEEF, 32'd0, 1'b0, 3, 1, 32'h14, 32'h1122BEEF);
    do_req("lw_14b", 6'h23, 32'h14, 32'd0, 32'h1122BEEF, 1'b0, 2, 0, 32'd0, 32'd0);

    // Back-pressure: response held while a new request waits
    resp_ready = 1'b0;
    sb.push_back('{"stall_lw_20", 32'hDEADBEEF, 1'b0, 2, 0, 32'd0, 32'd0});
    drive(6'h23, 32'h20, 32'd0);
    wait_accept("stall_lw_20");
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (resp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) timeout_fail("stall_resp");
    end
    sb.push_back('{"after_stall_lw_10", 32'h80FF7FAB, 1'b0, 2, 0, 32'd0, 32'd0});
    @(posedge clock);
    #1 drive(6'h23, 32'h10, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_resp_rdata", resp_rdata, 32'hDEADBEEF);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clock);
    end
    #1 resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clock);
    #1 req_valid = 1'b0;
    wait_done("after_stall_lw_10");

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit that sits between the CPU datapath and the word-only data memory.
- Accepts MIPS load/store requests (LB, LBU, LH, LHU, LW, SB, SH, SW) and checks alignment and range.
- Drives the memory port: combinational word read, word write when op==SW at posedge clock.
- Sub-word stores use a read-modify-write sequence. Load data is returned extracted and extended, big-endian byte order.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in data memory; byte addresses >= MEM_WORDS*4 are out of range
NOP_OP, 6'h00, value driven on mem_op when no write is issued

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_op  input  6  MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B
req_address  input  32  byte address
req_wdata  input  32  store data, sub-word taken from LSBs
resp_valid  output  1  response present, held until resp_ready
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  misaligned, out-of-range or unknown op
mem_op  output  6  0x2B during a write cycle, else NOP_OP
mem_address  output  32  word-aligned byte address {addr[31:2],2'b00}
mem_writevalue  output  32  word to write
mem_readvalue  input  32  combinational read of word at mem_address

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_op=NOP_OP, mem_address=0, mem_writevalue=0.
- Reset has priority over everything. When reset is high at an edge, the next state is IDLE from any state; a pending RMW write is abandoned and never issued.
- States: IDLE, ACCESS, WRITE, RESP.
- mem_* outputs are decoded from registered state and registers only. There is no combinational path from req_* to mem_*.

IDLE:
- Accept on req_valid && req_ready at an edge; register op, address and wdata.
- Error check at acceptance:
  - Unknown op.
  - Halfword op with addr[0]!=0.
  - Word op with addr[1:0]!=0.
  - addr >= MEM_WORDS*4.
- On error: go to RESP with resp_error=1 and resp_rdata=0. Memory is never touched.
- Otherwise: go to ACCESS.

ACCESS (1 cycle):
- mem_address is the aligned address.
- SW: mem_op=0x2B, mem_writevalue=wdata. The word is written at the end of this cycle. Next state RESP.
- Loads: capture mem_readvalue at the edge, extract and extend, load resp_rdata. Next state RESP.
- SB/SH: capture mem_readvalue into a merge register; mem_op stays NOP_OP. Next state WRITE.

WRITE (1 cycle, SB/SH only):
- mem_op=0x2B; mem_writevalue is the captured word with the target lane replaced. Next state RESP.

RESP:
- resp_valid=1. Leave on resp_valid && resp_ready, returning to IDLE; resp_valid clears the next cycle.
- req_ready=0 in every state except IDLE. A new request may be accepted one cycle after the response handshake.

Byte lanes (big-endian):
- addr[1:0]=0 selects bits 31:24, 1 selects 23:16, 2 selects 15:8, 3 selects 7:0.
- Halfword: addr[1]=0 selects bits 31:16, 1 selects 15:0.
- LB/LH sign-extend; LBU/LHU zero-extend.

Latency from the acceptance edge to first resp_valid cycle:
- Loads and SW: 2 cycles.
- SB/SH: 3 cycles.
- Errors: 1 cycle.

Write count:
- Exactly one mem_op=0x2B cycle per store.
- Zero write cycles for loads and errors.

Test Plan:
- Preload word[4]=0x80FF7F01. LB 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080; LH 0x12 -> 0x00007F01; LHU 0x10 -> 0x000080FF. Each has resp_valid 2 cycles after acceptance and resp_error=0.
- SB 0x13 with wdata 0x000000AB on word 0x80FF7F01 -> exactly one mem_op=0x2B cycle with writevalue 0x80FF7FAB. resp_valid 3 cycles after acceptance. Then LW 0x10 -> 0x80FF7FAB.
- SW 0x20 with 0xDEADBEEF -> one write cycle, mem_address 0x20. Then LW 0x20 -> 0xDEADBEEF.
- Error cases, each giving resp_error=1, resp_rdata=0, no mem_op=0x2B cycle, resp_valid 1 cycle after acceptance:
  - LW 0x22 (misaligned).
  - SH 0x11 (misaligned).
  - LW 0x1000 with MEM_WORDS=1024 (out of range).
  - op 0x3F (unknown).
- SH 0x14 with reset asserted for one edge while in ACCESS -> no write cycle, memory word unchanged. After reset: req_ready=1, resp_valid=0.
- LW with resp_ready held low 3 cycles -> resp_valid and resp_rdata stable, req_ready=0, a concurrent req_valid is ignored. On resp_ready=1: IDLE the next cycle, then the new request is accepted.
